data_store_ring: RTL and testbench
==================================

Name: data_store_ring

Overview:
- Per-channel sample store for the frequency-selector datapath: each sample arrives tagged with a channel index and is written to that channel's next free slot.
- Each channel keeps its own slot counter; reads use the address {slot, index}.
- Adds channel count, depth and width generalisation, ring and one-shot modes, a clear sequencer and back-to-back same-index forwarding.
- Memories are inferred in RTL; no vendor IP.

Parameters:
DATA_WIDTH  64   sample width in bits
N_FREQ      128  number of channels; must be a power of 2, at least 2
DEPTH       32   slots per channel; must be a power of 2, at least 2
(logN = $clog2(N_FREQ), logD = $clog2(DEPTH))

Ports:
clk           in   1               clock; the block has one clock
rst           in   1               synchronous, active-high reset
data_in       in   DATA_WIDTH      sample
index         in   logN            channel of the sample
valid         in   1               sample strobe; no backpressure
mode          in   1               0 = ring, 1 = one-shot; sampled only when a clear starts
clear         in   1               1-cycle pulse that starts a clear sequence
busy          out  1               clear sequence in progress
rd_en         in   1               read strobe
rd_addr       in   logD+logN       read address {slot, index}
data_out      out  DATA_WIDTH      read data
rd_valid      out  1               data_out valid
wrap          out  1               1-cycle pulse: a channel counter wrapped (ring) or filled (one-shot)
wrap_index    out  logN            channel that caused wrap
all_full      out  1               one-shot only: every channel holds DEPTH samples
n_full        out  logN+1          number of channels that have filled since the last clear

Behaviour:
- Reset:
  - busy=1, then a clear sequence runs automatically.
  - All other outputs reset to 0; mode register resets to 0.
  - Data memory contents are undefined after reset.
- Counter memory: N_FREQ entries of logD+1 bits, fields {full, cnt}.
- Write pipeline, three stages:
  - S0: counter RAM read at index.
  - S1: counter data available.
  - S2: data RAM written at {cnt, idx}; counter RAM written with the new value.
  - A sample accepted at cycle t is readable with rd_en at cycle t+3.
- Forwarding:
  - If the S0 index equals the S1 or S2 index, the counter value comes from the newest in-flight update, not from RAM.
  - Consecutive samples to the same channel therefore take consecutive slots, with no lost increments.
- Ring mode:
  - cnt increments modulo DEPTH.
  - On the transition DEPTH-1 -> 0: wrap=1 and wrap_index=idx in the S2 cycle.
  - The full bit is set on the first wrap; n_full increments once per channel.
- One-shot mode:
  - After the write that takes cnt from DEPTH-1 to full: wrap pulses and n_full increments.
  - Later samples for that channel are dropped: no data write, no counter change.
  - all_full = (n_full == N_FREQ).
- Clear state machine, states IDLE and CLR:
  - IDLE -> CLR on clear or after reset. Entering CLR latches mode and sets n_full=0 and all_full=0.
  - CLR writes 0 to one counter entry per cycle (0..N_FREQ-1), taking N_FREQ cycles, then returns to IDLE.
  - busy=1 throughout CLR.
  - valid is ignored while busy; samples in flight in S1/S2 when clear is asserted are discarded.
  - clear asserted while busy restarts the sweep at entry 0.
- Read port:
  - data_out and rd_valid follow rd_en by 1 cycle; rd_valid=0 otherwise, and data_out holds its last value.
  - A read of an address written in the same cycle returns the old data (read-first).
  - Reads are legal while busy and return stale data.
- Simultaneous rst and clear: rst wins.
- mode changes outside a clear take no effect.

Optional Feature:
DATA_STORE_DROP_CNT_EN
- Defined:
  - Adds output drop_count, 32 bits, reset 0, saturating at 0xFFFFFFFF.
  - Counts samples dropped because the channel is full (one-shot) or because valid arrived while busy.
  - Cleared at the start of each clear sequence.
- Undefined: the port is absent and no counter logic is generated.

Test Plan:
- Post-reset: busy stays high for 128 cycles, then 0. Write index=5 data=0xA at t -> read rd_addr={0,5} at t+3 gives data_out=0xA, rd_valid at t+4.
- Back-to-back same channel: 4 consecutive valids to index=7, data 1..4 -> slots 0..3 of channel 7 hold 1..4; no slot skipped or duplicated.
- Ring wrap: 33 samples to index=2 (data=k) -> wrap pulses once with wrap_index=2 on the 32nd; slot 0 holds 32; n_full=1.
- One-shot with N_FREQ=4, DEPTH=4: 4 samples per channel -> all_full=1, n_full=4. A 5th sample to channel 1 leaves slot 0 unchanged; drop_count=1 with the macro defined.
- Clear mid-stream: clear asserted while valid samples stream to index=3 -> in-flight samples are not written, busy=1 for N_FREQ cycles, the next sample lands in slot 0, and n_full=0.
- Reset during CLR: rst pulsed at cycle 20 of a clear -> the sweep restarts from entry 0 and busy stays high for a full N_FREQ cycles after rst deasserts.

Source files
------------

// File: rtl/data_store_ring.sv
// Per-channel sample store: each sample lands in its channel's next slot (ring or one-shot),
// with a clear sequencer and same-channel forwarding. Optional macro DATA_STORE_DROP_CNT_EN adds drop_count.
module data_store_ring #(
  parameter int DATA_WIDTH = 64,
  parameter int N_FREQ     = 128,
  parameter int DEPTH      = 32,
  localparam int LOGN      = $clog2(N_FREQ),
  localparam int LOGD      = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [LOGN-1:0]       index,
  input  logic                  valid,
  input  logic                  mode,
  input  logic                  clear,
  output logic                  busy,
  input  logic                  rd_en,
  input  logic [LOGD+LOGN-1:0]  rd_addr,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  rd_valid,
  output logic                  wrap,
  output logic [LOGN-1:0]       wrap_index,
  output logic                  all_full,
`ifdef DATA_STORE_DROP_CNT_EN
  output logic [31:0]           drop_count,
`endif
  output logic [LOGN:0]         n_full
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_CLR  = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [LOGN-1:0]     clr_ptr_q, clr_ptr_d;
  logic                enter_clr_s;
  logic                busy_q;
  logic                mode_q;

  logic [LOGD:0]       cnt_mem [N_FREQ];
  logic [DATA_WIDTH-1:0] data_mem [DEPTH*N_FREQ];

  logic                accept_s;
  logic                fwd_s1_s, fwd_s2_s;
  logic                s1_valid_q;
  logic [LOGN-1:0]     s1_idx_q;
  logic [DATA_WIDTH-1:0] s1_data_q;
  logic [LOGD:0]       cnt_rd_q;
  logic                fwd_vld_q;
  logic [LOGD:0]       fwd_val_q;

  logic [LOGD:0]       s1_old_s, s1_new_s;
  logic                s1_last_s, s1_we_s, s1_wrap_s, s1_first_s;

  logic                s2_valid_q, s2_we_q;
  logic [LOGN-1:0]     s2_idx_q;
  logic [LOGD-1:0]     s2_cnt_q;
  logic [LOGD:0]       s2_new_q;
  logic [DATA_WIDTH-1:0] s2_data_q;
  logic                s2_commit_s;

  logic                wrap_q;
  logic [LOGN-1:0]     wrap_index_q;
  logic [LOGN:0]       n_full_q, n_full_d;
  logic                all_full_q;
  logic [DATA_WIDTH-1:0] data_out_q;
  logic                rd_valid_q;

  // Clear sequencer next state: a clear (even mid-sweep) restarts the sweep at entry 0
  always_comb begin
    state_d     = state_q;
    clr_ptr_d   = clr_ptr_q;
    enter_clr_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (clear) begin
          state_d     = ST_CLR;
          clr_ptr_d   = '0;
          enter_clr_s = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CLR: begin
        if (clear) begin
          clr_ptr_d   = '0;
          enter_clr_s = 1'b1;
        end else if (clr_ptr_q == LOGN'(N_FREQ - 1)) begin
          state_d   = ST_IDLE;
          clr_ptr_d = '0;
        end else begin
          clr_ptr_d = clr_ptr_q + LOGN'(1);
        end
      end
      default: begin
        state_d     = ST_CLR;
        clr_ptr_d   = '0;
        enter_clr_s = 1'b1;
      end
    endcase
  end

  // Clear sequencer state; reset lands directly in the sweep
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_CLR;
      clr_ptr_q <= '0;
      busy_q    <= 1'b1;
      mode_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
      busy_q    <= (state_d == ST_CLR);
      if (enter_clr_s) begin
        mode_q <= mode;
      end
    end
  end

  assign accept_s = valid & ~busy_q & ~clear;
  // The S2 entry updates RAM this very cycle, so both older stages must be bypassed
  assign fwd_s1_s = s1_valid_q & (s1_idx_q == index);
  assign fwd_s2_s = s2_valid_q & (s2_idx_q == index);

  // S1: counter update; a full channel in one-shot keeps its value and skips the write
  always_comb begin
    s1_old_s   = fwd_vld_q ? fwd_val_q : cnt_rd_q;
    s1_last_s  = (s1_old_s[LOGD-1:0] == LOGD'(DEPTH - 1));
    s1_new_s   = s1_old_s;
    s1_we_s    = 1'b0;
    s1_wrap_s  = 1'b0;
    s1_first_s = 1'b0;
    if (s1_valid_q && !(mode_q && s1_old_s[LOGD])) begin
      s1_we_s    = 1'b1;
      s1_new_s   = {s1_old_s[LOGD] | s1_last_s, s1_old_s[LOGD-1:0] + LOGD'(1)};
      s1_wrap_s  = s1_last_s;
      s1_first_s = s1_last_s & ~s1_old_s[LOGD];
    end else begin
      s1_new_s = s1_old_s;
    end
  end

  // Write pipeline registers S0->S1->S2; a clear discards whatever is in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_idx_q   <= '0;
      s1_data_q  <= '0;
      fwd_vld_q  <= 1'b0;
      fwd_val_q  <= '0;
      s2_valid_q <= 1'b0;
      s2_we_q    <= 1'b0;
      s2_idx_q   <= '0;
      s2_cnt_q   <= '0;
      s2_new_q   <= '0;
      s2_data_q  <= '0;
    end else begin
      s1_valid_q <= accept_s;
      s1_idx_q   <= index;
      s1_data_q  <= data_in;
      fwd_vld_q  <= fwd_s1_s | fwd_s2_s;
      fwd_val_q  <= fwd_s1_s ? s1_new_s : s2_new_q;
      s2_valid_q <= s1_valid_q & ~clear;
      s2_we_q    <= s1_we_s & ~clear;
      s2_idx_q   <= s1_idx_q;
      s2_cnt_q   <= s1_old_s[LOGD-1:0];
      s2_new_q   <= s1_new_s;
      s2_data_q  <= s1_data_q;
    end
  end

  assign s2_commit_s = s2_we_q & ~clear & ~busy_q;

  // Counter RAM: sweep writes while clearing, S2 update otherwise; read-first at S0
  always_ff @(posedge clk) begin
    if (state_q == ST_CLR) begin
      cnt_mem[clr_ptr_q] <= '0;
    end else if (s2_commit_s) begin
      cnt_mem[s2_idx_q] <= s2_new_q;
    end
    cnt_rd_q <= cnt_mem[index];
  end

  // Data RAM write port at {slot, channel}
  always_ff @(posedge clk) begin
    if (s2_commit_s) begin
      data_mem[{s2_cnt_q, s2_idx_q}] <= s2_data_q;
    end
  end

  // Read port: one-cycle latency, data held between reads
  always_ff @(posedge clk) begin
    if (rst) begin
      data_out_q <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= rd_en;
      if (rd_en) begin
        data_out_q <= data_mem[rd_addr];
      end
    end
  end

  assign n_full_d = n_full_q + (LOGN+1)'(s1_first_s);

  // Wrap pulse and fill status, visible in the S2 cycle of the causing sample
  always_ff @(posedge clk) begin
    if (rst) begin
      wrap_q       <= 1'b0;
      wrap_index_q <= '0;
      n_full_q     <= '0;
      all_full_q   <= 1'b0;
    end else if (enter_clr_s) begin
      wrap_q     <= 1'b0;
      n_full_q   <= '0;
      all_full_q <= 1'b0;
    end else begin
      wrap_q     <= s1_wrap_s;
      if (s1_wrap_s) begin
        wrap_index_q <= s1_idx_q;
      end
      n_full_q   <= n_full_d;
      all_full_q <= mode_q & (n_full_d == (LOGN+1)'(N_FREQ));
    end
  end

`ifdef DATA_STORE_DROP_CNT_EN
  logic [31:0] drop_cnt_q;
  logic        drop_busy_s, drop_full_s;

  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [1:0] b);
    logic [32:0] sum;
    sum = {1'b0, a} + 33'(b);
    return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
  endfunction

  assign drop_busy_s = valid & busy_q;
  assign drop_full_s = s1_valid_q & mode_q & s1_old_s[LOGD];

  // Saturating count of samples refused while busy or for a full one-shot channel
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt_q <= 32'h0000_0000;
    end else if (enter_clr_s) begin
      drop_cnt_q <= 32'h0000_0000;
    end else begin
      drop_cnt_q <= sat_add(drop_cnt_q, {1'b0, drop_busy_s} + {1'b0, drop_full_s});
    end
  end

  assign drop_count = drop_cnt_q;
`endif

  assign busy       = busy_q;
  assign data_out   = data_out_q;
  assign rd_valid   = rd_valid_q;
  assign wrap       = wrap_q;
  assign wrap_index = wrap_index_q;
  assign all_full   = all_full_q;
  assign n_full     = n_full_q;

endmodule

// File: tb/tb_data_store_ring.sv
// Scoreboard bench for data_store_ring: reads and wrap pulses are checked by a monitor
// against queued expectations; status outputs are checked directly at known cycles.
module tb_data_store_ring;
  localparam int DW = 64;
  localparam int NF = 128;
  localparam int DP = 32;
  localparam int LN = 7;
  localparam int LD = 5;

  logic          clk = 1'b0;
  logic          rst, valid, mode, clear, rd_en;
  logic [DW-1:0] data_in;
  logic [LN-1:0] index;
  logic [LD+LN-1:0] rd_addr;
  logic          busy, rd_valid, wrap, all_full;
  logic [DW-1:0] data_out;
  logic [LN-1:0] wrap_index;
  logic [LN:0]   n_full;
`ifdef DATA_STORE_DROP_CNT_EN
  logic [31:0]   drop_count;
`endif

  always #5 clk = ~clk;

  data_store_ring #(.DATA_WIDTH(DW), .N_FREQ(NF), .DEPTH(DP)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .index(index), .valid(valid),
    .mode(mode), .clear(clear), .busy(busy), .rd_en(rd_en), .rd_addr(rd_addr),
    .data_out(data_out), .rd_valid(rd_valid), .wrap(wrap), .wrap_index(wrap_index),
    .all_full(all_full),
`ifdef DATA_STORE_DROP_CNT_EN
    .drop_count(drop_count),
`endif
    .n_full(n_full)
  );

  int n_cmp = 0;
  int n_err = 0;
  logic [DW-1:0] rd_exp_q[$];
  logic [LN-1:0] wrap_exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops expectations whenever the DUT presents read data or a wrap pulse
  always @(negedge clk) begin
    if (rd_valid === 1'b1) begin
      if (rd_exp_q.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL rd_unexpected: got data %0h expected no read", data_out);
      end else begin
        check("rd_data", data_out, rd_exp_q.pop_front());
      end
    end
    if (wrap === 1'b1) begin
      if (wrap_exp_q.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL wrap_unexpected: got index %0d expected no wrap", wrap_index);
      end else begin
        check("wrap_index", 64'(wrap_index), 64'(wrap_exp_q.pop_front()));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic put(input int ch, input logic [DW-1:0] d);
    valid = 1'b1; index = ch[LN-1:0]; data_in = d;
    @(negedge clk);
    valid = 1'b0;
  endtask

  task automatic rd(input int slot, input int ch, input logic [DW-1:0] e);
    rd_en = 1'b1; rd_addr = {slot[LD-1:0], ch[LN-1:0]};
    rd_exp_q.push_back(e);
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic count_busy(output int n);
    n = 0;
    while (busy === 1'b1 && n < 1000) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic do_clear(input logic m, output int n);
    mode = m; clear = 1'b1;
    @(negedge clk);
    clear = 1'b0; mode = 1'b0;
    count_busy(n);
  endtask

  initial begin
    int n;
    rst = 1'b1; valid = 1'b0; mode = 1'b0; clear = 1'b0; rd_en = 1'b0;
    data_in = '0; index = '0; rd_addr = '0;
    idle(3);
    check("rst_busy", 64'(busy), 64'd1);
    check("rst_rd_valid", 64'(rd_valid), 64'd0);
    check("rst_wrap", 64'(wrap), 64'd0);
    check("rst_n_full", 64'(n_full), 64'd0);
    check("rst_all_full", 64'(all_full), 64'd0);
    check("rst_data_out", data_out, 64'd0);
    rst = 1'b0;
    count_busy(n);
    check("reset_busy_cycles", 64'(n), 64'd128);

    // First write visible to a read three cycles later
    put(5, 64'hA);
    idle(2);
    rd(0, 5, 64'hA);
    check("rd_valid_t4", 64'(rd_valid), 64'd1);
    idle(1);
    check("rd_valid_low", 64'(rd_valid), 64'd0);
    check("data_out_hold", data_out, 64'hA);

    // Back-to-back same channel and S2-only forwarding
    for (int k = 1; k <= 4; k++) put(7, 64'(k));
    put(9, 64'h91); put(10, 64'hA0); put(9, 64'h92);
    idle(2);
    put(7, 64'd5);
    idle(3);
    for (int k = 0; k < 5; k++) rd(k, 7, 64'(k + 1));
    rd(0, 9, 64'h91); rd(1, 9, 64'h92); rd(0, 10, 64'hA0);

    // Ring wrap on channel 2, plus read-first on the overwritten slot
    for (int k = 0; k < 32; k++) begin
      if (k == 31) wrap_exp_q.push_back(7'd2);
      put(2, 64'(k));
    end
    idle(1);
    put(2, 64'd32);
    idle(1);
    rd(0, 2, 64'd0);
    rd(0, 2, 64'd32);
    rd(1, 2, 64'd1);
    idle(2);
    check("ring_n_full", 64'(n_full), 64'd1);
    check("ring_all_full", 64'(all_full), 64'd0);

    // Clear while streaming to channel 3: in-flight samples never land
    put(3, 64'h30); put(3, 64'h31); put(3, 64'h32);
    idle(3);
    do_clear(1'b0, n);
    check("clear1_busy_cycles", 64'(n), 64'd128);
    put(3, 64'd100); put(3, 64'd101); put(3, 64'd102);
    valid = 1'b1; index = 7'd3; data_in = 64'd103; clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 1000) begin
      valid = (n < 3); data_in = 64'(200 + n);
      n++;
      @(negedge clk);
    end
    valid = 1'b0;
    check("clear2_busy_cycles", 64'(n), 64'd128);
    check("clear_n_full", 64'(n_full), 64'd0);
`ifdef DATA_STORE_DROP_CNT_EN
    check("drop_busy", 64'(drop_count), 64'd3);
`endif
    rd(0, 3, 64'd100); rd(1, 3, 64'h31); rd(2, 3, 64'h32);
    put(3, 64'h77);
    idle(2);
    rd(0, 3, 64'h77); rd(1, 3, 64'h31);

    // Reset 20 cycles into a clear restarts a full sweep
    mode = 1'b1; clear = 1'b1;
    @(negedge clk);
    clear = 1'b0; mode = 1'b0;
    idle(19);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    count_busy(n);
    check("rst_in_clr_busy_cycles", 64'(n), 64'd128);

    // One-shot: fill every channel, then a surplus sample is dropped
    do_clear(1'b1, n);
    check("oneshot_busy_cycles", 64'(n), 64'd128);
    for (int c = 0; c < NF; c++) begin
      if (c == NF - 1) begin
        idle(3);
        check("n_full_127", 64'(n_full), 64'd127);
        check("all_full_early", 64'(all_full), 64'd0);
      end
      for (int s = 0; s < DP; s++) begin
        if (s == DP - 1) wrap_exp_q.push_back(c[LN-1:0]);
        put(c, 64'(c * 256 + s));
      end
    end
    idle(3);
    check("all_full", 64'(all_full), 64'd1);
    check("n_full_all", 64'(n_full), 64'd128);
    put(1, 64'hDEAD);
    idle(3);
    rd(0, 1, 64'h100); rd(31, 1, 64'h11F); rd(5, 64, 64'h4005);
    check("n_full_after_drop", 64'(n_full), 64'd128);
`ifdef DATA_STORE_DROP_CNT_EN
    check("drop_full", 64'(drop_count), 64'd1);
`endif

    idle(3);
    check("rd_queue_drained", 64'(rd_exp_q.size()), 64'd0);
    check("wrap_queue_drained", 64'(wrap_exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
